// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multicycle fetch/read/exec/write sequencer for regfile + alu (optional TRAP_UNDEF_EN: trap opcodes 11-14)
module instr_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_prog_we,
    input  logic [PC_W-1:0] i_prog_addr,
    input  logic [15:0]     i_prog_data,
    input  logic            i_start,
    output logic [15:0]     o_instruction,
    output logic            o_enable_write,
    output logic [PC_W-1:0] o_pc,
    output logic            o_busy,
    output logic            o_halted,
    output logic            o_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_READ  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_mem [PROG_DEPTH];
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      w_opcode;
    logic            w_undef;
    logic            w_stopped;
    logic            w_launch;

    assign w_opcode  = r_instr[15:12];
    // Opcodes 11-14 have no ALU meaning; they never write the regfile.
    assign w_undef   = (w_opcode >= 4'd11) && (w_opcode <= 4'd14);
    // IDLE and HALT both accept program writes and a start pulse.
    assign w_stopped = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_launch  = w_stopped && i_start;

    // Program store: written only while the sequencer is not running.
    always_ff @(posedge i_clk) begin
        if (i_prog_we && w_stopped) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: one clock per state, four per instruction.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC: begin
                if (w_opcode == 4'd15) begin
                    w_next = S_HALT;
`ifdef TRAP_UNDEF_EN
                end else if (w_undef) begin
                    w_next = S_HALT;
`endif
                end else begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = S_FETCH;
            S_HALT:  if (i_start) w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef TRAP_UNDEF_EN
    logic r_error;

    // Trap flag: set when an undefined opcode reaches EXEC, cleared on a new run.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_error <= 1'b0;
        end else if (w_launch) begin
            r_error <= 1'b0;
        end else if ((r_state == S_EXEC) && w_undef) begin
            r_error <= 1'b1;
        end
    end
`endif

    // Program counter and instruction latch; instruction only changes at the end of FETCH.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= '0;
            r_instr <= '0;
        end else if (w_launch) begin
            r_pc <= '0;
        end else if (r_state == S_FETCH) begin
            r_instr <= r_mem[r_pc];
        end else if (r_state == S_WRITE) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    // Outputs decoded from the current state; the write strobe spans the whole WRITE cycle.
    always_comb begin
        o_instruction  = r_instr;
        o_pc           = r_pc;
        o_busy         = (r_state == S_FETCH) || (r_state == S_READ) ||
                         (r_state == S_EXEC)  || (r_state == S_WRITE);
        o_halted       = (r_state == S_HALT);
        o_enable_write = (r_state == S_WRITE) && !w_undef;
`ifdef TRAP_UNDEF_EN
        o_error        = r_error;
`else
        o_error        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer with cycle model and regfile/alu stand-in
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic [15:0] instruction;
    logic        enable_write;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic        error;

    always #5 clk = ~clk;

    instr_sequencer #(.PROG_DEPTH(16), .PC_W(4)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_prog_we      (prog_we),
        .i_prog_addr    (prog_addr),
        .i_prog_data    (prog_data),
        .i_start        (start),
        .o_instruction  (instruction),
        .o_enable_write (enable_write),
        .o_pc           (pc),
        .o_busy         (busy),
        .o_halted       (halted),
        .o_error        (error)
    );

`ifdef TRAP_UNDEF_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 0;
    int          ew_count = 0;
    logic [31:0] ew_mask;
    logic [15:0] regs [16];

    // Model: program image plus position within the 4-cycle instruction slot.
    logic [15:0] m_mem [16];
    bit          m_active = 0;
    bit          m_halted = 0;
    bit          m_error = 0;
    int          m_slot = 0;
    int          m_pc = 0;
    logic [15:0] m_instr = '0;

    function automatic bit is_undef(logic [15:0] w);
        return (w[15:12] >= 4'd11) && (w[15:12] <= 4'd14);
    endfunction

    function automatic logic [15:0] alu(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_active = 0; m_halted = 0; m_error = 0;
            m_slot = 0; m_pc = 0; m_instr = '0;
        end else if (!m_active) begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                m_active = 1; m_halted = 0; m_error = 0; m_pc = 0; m_slot = 0;
            end
        end else begin
            case (m_slot)
                0: begin m_instr = m_mem[m_pc]; m_slot = 1; end
                1: m_slot = 2;
                2: begin
                    if (m_instr[15:12] == 4'd15) begin
                        m_active = 0; m_halted = 1;
                    end else if (TRAP && is_undef(m_instr)) begin
                        m_active = 0; m_halted = 1; m_error = 1;
                    end else begin
                        m_slot = 3;
                    end
                end
                default: begin m_pc = (m_pc + 1) % 16; m_slot = 0; end
            endcase
        end
    endtask

    // One clock: compare at negedge, regfile write at negedge, model advance, then move past posedge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_active));
            check("halted", 32'(halted), 32'(m_halted));
            check("error", 32'(error), 32'(m_error));
            check("pc", 32'(pc), 32'(m_pc));
            check("instruction", 32'(instruction), 32'(m_instr));
            check("enable_write", 32'(enable_write),
                  32'(m_active && (m_slot == 3) && !is_undef(m_instr)));
        end
        if (enable_write === 1'b1) begin
            regs[instruction[11:8]] = alu(instruction[15:12], regs[instruction[7:4]], regs[instruction[3:0]]);
            ew_count++;
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        tick();
        chk_en = 1;
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_instr", 32'(instruction), 32'd0);
        check("reset_ew", 32'(enable_write), 32'd0);
        reset = 1'b0;

        // Add then HALT: write strobe only in cycle 4, halt after cycle 7.
        for (int i = 0; i < 16; i++) load(4'(i), 16'hF000);
        load(4'd0, 16'h0F73);
        regs[3] = 16'd5; regs[7] = 16'd1;
        start = 1'b1; tick(); start = 1'b0;
        ew_mask = '0;
        for (int k = 1; k <= 7; k++) begin
            if (enable_write === 1'b1) ew_mask = ew_mask | (32'd1 << k);
            tick();
        end
        check("t2_ew_cycle", ew_mask, 32'h10);
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_pc", 32'(pc), 32'd1);
        check("t2_r15", 32'(regs[15]), 32'd6);

        // Subtract; program word written in the same halted cycle as start.
        regs[3] = 16'd5; regs[7] = 16'd1;
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h1373;
        tick();
        start = 1'b0; prog_we = 1'b0;
        ew_count = 0;
        repeat (10) tick();
        check("t3_r3", 32'(regs[3]), 32'hFFFC);
        check("t3_ew_pulses", 32'(ew_count), 32'd1);
        check("t3_halted", 32'(halted), 32'd1);

        // Reset arriving at the edge that would enter WRITE suppresses the write.
        load(4'd0, 16'h0F73);
        regs[15] = 16'hAAAA; regs[3] = 16'd5; regs[7] = 16'd1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick();
        check("t1_ew", 32'(enable_write), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_pc", 32'(pc), 32'd0);
        reset = 1'b0; tick();
        check("t1_r15", 32'(regs[15]), 32'hAAAA);

        // No HALT anywhere: pc wraps 15 -> 0 without error.
        for (int i = 0; i < 16; i++) load(4'(i), 16'h9F70);
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 18; n++) begin
            check("t4_pc_seq", 32'(pc), 32'(n % 16));
            check("t4_error", 32'(error), 32'd0);
            repeat (4) tick();
        end
        reset = 1'b1; tick(); reset = 1'b0; tick();

        // Undefined opcode.
        load(4'd0, 16'hB000);
        ew_count = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
`ifdef TRAP_UNDEF_EN
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_error", 32'(error), 32'd1);
        check("t5_pc", 32'(pc), 32'd0);
        check("t5_no_write", 32'(ew_count), 32'd0);
`else
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_ew", 32'(enable_write), 32'd0);
        tick();
        check("t5_pc", 32'(pc), 32'd1);
        check("t5_no_write", 32'(ew_count), 32'd0);
        check("t5_error", 32'(error), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

        // start and prog_we while busy are ignored; re-run after HALT.
        load(4'd0, 16'h0000); load(4'd1, 16'h0000); load(4'd2, 16'hF000);
        ew_count = 0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 16'h0F73;
        tick(); tick();
        start = 1'b0; prog_we = 1'b0;
        repeat (8) tick();
        check("t6_halted", 32'(halted), 32'd1);
        check("t6_pc", 32'(pc), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        check("t6_rerun_halted", 32'(halted), 32'd1);
        check("t6_rerun_pc", 32'(pc), 32'd2);
        check("t6_rerun_instr", 32'(instruction), 32'hF000);
        check("t6_writes", 32'(ew_count), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
